// File: rtl/wb_cp0_pkg.sv
// Shared CP0 constants: register addresses {reg,sel}, exception codes and
// the Status/Cause field positions used by wb_cp0 and its testbench.
package wb_cp0_pkg;

  localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int ST_IM_HI  = 15;

  localparam int CA_EXC_LO = 2;
  localparam int CA_EXC_HI = 6;
  localparam int CA_IPS_LO = 8;
  localparam int CA_IPS_HI = 9;
  localparam int CA_IPH_LO = 10;
  localparam int CA_IPH_HI = 15;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

endpackage

// File: rtl/wb_cp0_if.sv
// Write-back stage <-> CP0 bus: decoded WB events, mtc0/mfc0 access,
// interrupt lines, and the exception redirect returned to the pipeline.
interface wb_cp0_if #(
  parameter int HW_INT_N = 6
);
  logic                WB_valid;
  logic [31:0]         pc;
  logic                bd;
  logic                syscall;
  logic                brk;
  logic                eret;
  logic                ov;
  logic                adel;
  logic                ades;
  logic [31:0]         badvaddr;
  logic                mtc0;
  logic                mfc0;
  logic [7:0]          cp0r_addr;
  logic [31:0]         cp0_wdata;
  logic [HW_INT_N-1:0] hw_int;
  logic [31:0]         cp0_rdata;
  logic [32:0]         exc_bus;
  logic                cancel;
  logic                int_pending;

  modport master (
    output WB_valid, pc, bd, syscall, brk, eret, ov, adel, ades, badvaddr,
           mtc0, mfc0, cp0r_addr, cp0_wdata, hw_int,
    input  cp0_rdata, exc_bus, cancel, int_pending
  );

  modport slave (
    input  WB_valid, pc, bd, syscall, brk, eret, ov, adel, ades, badvaddr,
           mtc0, mfc0, cp0r_addr, cp0_wdata, hw_int,
    output cp0_rdata, exc_bus, cancel, int_pending
  );
endinterface

// File: rtl/wb_cp0_timer.sv
// CP0 Count/Compare timer: Count advances once per COUNT_DIV cycles and
// raises TI when the post-increment Count equals Compare.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_count_i,
  input  logic        wr_compare_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        phase_q, phase_d;
  logic        ti_q, ti_d;
  logic        tick;

  assign tick = (COUNT_DIV == 1) ? 1'b1 : phase_q;

  always_comb begin
    phase_d   = (COUNT_DIV == 1) ? 1'b0 : ~phase_q;
    count_d   = count_q + {31'd0, tick};
    compare_d = compare_q;
    ti_d      = ti_q;
    // A Count write both overrides the increment and restarts the divider.
    if (wr_count_i) begin
      count_d = wdata_i;
      phase_d = 1'b0;
    end
    if (wr_compare_i) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end else if (tick && !wr_count_i && (count_d == compare_q)) begin
      ti_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      phase_q   <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      phase_q   <= phase_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/wb_cp0.sv
// Write-back stage CP0: Status/Cause/EPC/BadVAddr, exception/eret redirect.
// Define CP0_TIMER_EN to include the Count/Compare timer (cp0_timer).
module wb_cp0
  import wb_cp0_pkg::*;
#(
  parameter int          HW_INT_N  = 6,
  parameter logic [31:0] EXC_BASE  = 32'd0,
  parameter int          COUNT_DIV = 2
) (
  input logic     clk,
  input logic     resetn,
  wb_cp0_if.slave bus
);

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  iphw_q, iphw_d;
  logic [1:0]  ipsw_q, ipsw_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] bva_q, bva_d;

  logic [31:0] count, compare;
  logic        ti;
  logic [5:0]  hw6;
  logic        int_pend;
  logic        exc_take, eret_take, evt_take, wr_en;
  logic [4:0]  code;
  logic        addr_fault;
  logic [31:0] rdata;
  logic [32:0] exc_bus;

  always_comb begin
    hw6 = '0;
    hw6[HW_INT_N-1:0] = bus.hw_int;
  end

  assign int_pend = ie_q & ~exl_q & (|({iphw_q, ipsw_q} & im_q));

  always_comb begin
    code       = EXC_INT;
    addr_fault = 1'b0;
    if (int_pend) begin
      code = EXC_INT;
    end else if (bus.adel) begin
      code       = EXC_ADEL;
      addr_fault = 1'b1;
    end else if (bus.ades) begin
      code       = EXC_ADES;
      addr_fault = 1'b1;
    end else if (bus.ov) begin
      code = EXC_OV;
    end else if (bus.syscall) begin
      code = EXC_SYS;
    end else if (bus.brk) begin
      code = EXC_BP;
    end
  end

  assign exc_take  = bus.WB_valid & (int_pend | bus.adel | bus.ades | bus.ov |
                                     bus.syscall | bus.brk);
  assign eret_take = bus.WB_valid & bus.eret & ~exc_take;
  assign evt_take  = exc_take | eret_take;
  assign wr_en     = bus.mtc0 & ~evt_take;

  // Redirect is forced quiet while reset is held, even if WB events are driven.
  always_comb begin
    exc_bus = '0;
    if (resetn && exc_take)       exc_bus = {1'b1, EXC_BASE};
    else if (resetn && eret_take) exc_bus = {1'b1, epc_q};
  end

  always_comb begin
    im_d   = im_q;
    exl_d  = exl_q;
    ie_d   = ie_q;
    bd_d   = bd_q;
    ipsw_d = ipsw_q;
    exc_d  = exc_q;
    epc_d  = epc_q;
    bva_d  = bva_q;
    iphw_d = hw6 | {ti, 5'd0};
    if (wr_en) begin
      case (bus.cp0r_addr)
        CP0_STATUS: begin
          im_d  = bus.cp0_wdata[ST_IM_HI:ST_IM_LO];
          exl_d = bus.cp0_wdata[ST_EXL];
          ie_d  = bus.cp0_wdata[ST_IE];
        end
        CP0_CAUSE: ipsw_d = bus.cp0_wdata[CA_IPS_HI:CA_IPS_LO];
        CP0_EPC:   epc_d  = bus.cp0_wdata;
        default:   ;
      endcase
    end
    // A nested exception (EXL already set) only refreshes ExcCode.
    if (exc_take) begin
      exl_d = 1'b1;
      exc_d = code;
      if (!exl_q) begin
        bd_d  = bus.bd;
        epc_d = bus.bd ? (bus.pc - 32'd4) : bus.pc;
        if (addr_fault) bva_d = bus.badvaddr;
      end
    end else if (eret_take) begin
      exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      im_q   <= '0;
      exl_q  <= 1'b0;
      ie_q   <= 1'b0;
      bd_q   <= 1'b0;
      iphw_q <= '0;
      ipsw_q <= '0;
      exc_q  <= '0;
      epc_q  <= '0;
      bva_q  <= '0;
    end else begin
      im_q   <= im_d;
      exl_q  <= exl_d;
      ie_q   <= ie_d;
      bd_q   <= bd_d;
      iphw_q <= iphw_d;
      ipsw_q <= ipsw_d;
      exc_q  <= exc_d;
      epc_q  <= epc_d;
      bva_q  <= bva_d;
    end
  end

`ifdef CP0_TIMER_EN
  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk          (clk),
    .resetn       (resetn),
    .wr_count_i   (wr_en && (bus.cp0r_addr == CP0_COUNT)),
    .wr_compare_i (wr_en && (bus.cp0r_addr == CP0_COMPARE)),
    .wdata_i      (bus.cp0_wdata),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );
`else
  assign count   = 32'd0;
  assign compare = 32'd0;
  assign ti      = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (bus.mfc0) begin
      case (bus.cp0r_addr)
        CP0_STATUS:   rdata = {16'd0, im_q, 6'd0, exl_q, ie_q};
        CP0_CAUSE:    rdata = {bd_q, ti, 14'd0, iphw_q, ipsw_q, 1'b0, exc_q, 2'd0};
        CP0_EPC:      rdata = epc_q;
        CP0_BADVADDR: rdata = bva_q;
        CP0_COUNT:    rdata = count;
        CP0_COMPARE:  rdata = compare;
        default:      rdata = '0;
      endcase
    end
  end

  assign bus.cp0_rdata   = rdata;
  assign bus.exc_bus     = exc_bus;
  assign bus.cancel      = exc_bus[32];
  assign bus.int_pending = int_pend;

endmodule

// File: tb/tb_wb_cp0.sv
// Bench for wb_cp0: register table, directed exception/timer/reset sequences
// and randomized traffic, all checked against an in-bench CP0 model.
module tb_wb_cp0;
  import wb_cp0_pkg::*;

  localparam logic [31:0] EXC_BASE_TB = 32'h8000_0180;
`ifdef CP0_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        bd;
    logic        sys, brk, eret, ov, adel, ades;
    logic [31:0] bva;
    logic        mtc0, mfc0;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [5:0]  hw;
  } in_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [5:0] cur_hw = '0;

  logic [31:0] s_rdata;
  logic [32:0] s_exc;
  logic        s_cancel, s_pend;

  // model state
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [5:0]  m_hwip;
  logic [1:0]  m_swip;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_bva, m_count, m_cmp;

  always #5 clk = ~clk;

  wb_cp0_if #(.HW_INT_N(6)) bus ();

  wb_cp0 #(
    .HW_INT_N  (6),
    .EXC_BASE  (EXC_BASE_TB),
    .COUNT_DIV (1)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0;
    m_hwip = '0; m_swip = '0; m_code = '0; m_epc = '0; m_bva = '0;
    m_count = '0;
    m_cmp = TIMER_ON ? 32'hFFFF_FFFF : 32'h0;
  endfunction

  function automatic logic m_pending();
    return m_ie && !m_exl && (({m_hwip, m_swip} & m_im) != 8'd0);
  endfunction

  function automatic void m_event(input in_t v, output logic take, output logic er,
                                  output logic [4:0] code, output logic isa);
    take = 0; er = 0; code = 0; isa = 0;
    if (v.valid) begin
      if (m_pending())  begin take = 1; code = 5'd0; end
      else if (v.adel)  begin take = 1; code = 5'd4; isa = 1; end
      else if (v.ades)  begin take = 1; code = 5'd5; isa = 1; end
      else if (v.ov)    begin take = 1; code = 5'd12; end
      else if (v.sys)   begin take = 1; code = 5'd8; end
      else if (v.brk)   begin take = 1; code = 5'd9; end
      else if (v.eret)  er = 1;
    end
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      CP0_STATUS:   return {16'd0, m_im, 6'd0, m_exl, m_ie};
      CP0_CAUSE:    return {m_bd, m_ti, 14'd0, m_hwip, m_swip, 1'b0, m_code, 2'd0};
      CP0_EPC:      return m_epc;
      CP0_BADVADDR: return m_bva;
      CP0_COUNT:    return TIMER_ON ? m_count : 32'd0;
      CP0_COMPARE:  return TIMER_ON ? m_cmp : 32'd0;
      default:      return 32'd0;
    endcase
  endfunction

  function automatic void m_step(input in_t v);
    logic take, er, isa, wr, exl_old;
    logic [4:0] code;
    logic [5:0] hw_next;
    m_event(v, take, er, code, isa);
    hw_next = v.hw | {m_ti, 5'd0};
    wr = v.mtc0 && !take && !er;
    exl_old = m_exl;
    if (TIMER_ON) begin
      if (wr && v.addr == CP0_COMPARE) begin
        m_cmp = v.wdata;
        m_ti = 0;
      end else if (!(wr && v.addr == CP0_COUNT) && (m_count + 32'd1 == m_cmp)) begin
        m_ti = 1;
      end
      m_count = (wr && v.addr == CP0_COUNT) ? v.wdata : m_count + 32'd1;
    end
    if (wr) begin
      if (v.addr == CP0_STATUS) begin
        m_im = v.wdata[15:8]; m_exl = v.wdata[1]; m_ie = v.wdata[0];
      end
      if (v.addr == CP0_CAUSE) m_swip = v.wdata[9:8];
      if (v.addr == CP0_EPC)   m_epc = v.wdata;
    end
    if (take) begin
      m_exl = 1;
      m_code = code;
      if (!exl_old) begin
        m_bd = v.bd;
        m_epc = v.bd ? v.pc - 32'd4 : v.pc;
        if (isa) m_bva = v.bva;
      end
    end else if (er) begin
      m_exl = 0;
    end
    m_hwip = hw_next;
  endfunction

  task automatic drive(input in_t v);
    bus.WB_valid = v.valid; bus.pc = v.pc; bus.bd = v.bd;
    bus.syscall = v.sys; bus.brk = v.brk; bus.eret = v.eret; bus.ov = v.ov;
    bus.adel = v.adel; bus.ades = v.ades; bus.badvaddr = v.bva;
    bus.mtc0 = v.mtc0; bus.mfc0 = v.mfc0; bus.cp0r_addr = v.addr;
    bus.cp0_wdata = v.wdata; bus.hw_int = v.hw;
  endtask

  function automatic in_t idle();
    in_t v;
    v = '0;
    v.hw = cur_hw;
    return v;
  endfunction

  // One clock: drive after the edge, compare at the falling edge, then advance the model.
  task automatic cyc(input in_t v);
    logic take, er, isa;
    logic [4:0] code;
    logic [32:0] e_exc;
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    m_event(v, take, er, code, isa);
    e_exc = take ? {1'b1, EXC_BASE_TB} : (er ? {1'b1, m_epc} : 33'd0);
    s_rdata = bus.cp0_rdata; s_exc = bus.exc_bus;
    s_cancel = bus.cancel; s_pend = bus.int_pending;
    chk("exc_bus", s_exc, e_exc);
    chk("cancel", s_cancel, e_exc[32]);
    chk("int_pending", s_pend, m_pending());
    chk("cp0_rdata", s_rdata, v.mfc0 ? m_read(v.addr) : 32'd0);
    m_step(v);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    in_t v;
    v = idle(); v.mtc0 = 1; v.addr = a; v.wdata = d;
    cyc(v);
  endtask

  task automatic rd(input logic [7:0] a);
    in_t v;
    v = idle(); v.mfc0 = 1; v.addr = a;
    cyc(v);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    resetn = 0;
    m_reset();
    drive(idle());
    @(negedge clk);
    @(negedge clk);
    resetn = 1;
  endtask

  vec_t tbl[10];
  logic [7:0] alist[8];

  initial begin
    in_t v;
    int n;
    logic found;
    logic [31:0] r;

    m_reset();
    drive(idle());
    do_reset();

    // reset values
    rd(CP0_STATUS);   chk("rst_status", s_rdata, 32'h0);
    rd(CP0_CAUSE);    chk("rst_cause", s_rdata, 32'h0);
    rd(CP0_EPC);      chk("rst_epc", s_rdata, 32'h0);
    rd(CP0_BADVADDR); chk("rst_badvaddr", s_rdata, 32'h0);
    rd(CP0_COMPARE);  chk("rst_compare", s_rdata, TIMER_ON ? 32'hFFFF_FFFF : 32'h0);

    tbl[0] = '{CP0_STATUS,   32'hFFFF_FFFF, 32'h0000_FF03};
    tbl[1] = '{CP0_CAUSE,    32'hFFFF_FFFF, 32'h0000_0300};
    tbl[2] = '{CP0_STATUS,   32'h0000_0000, 32'h0000_0000};
    tbl[3] = '{CP0_CAUSE,    32'h0000_0000, 32'h0000_0000};
    tbl[4] = '{CP0_EPC,      32'h1234_5678, 32'h1234_5678};
    tbl[5] = '{CP0_BADVADDR, 32'hDEAD_BEEF, 32'h0000_0000};
    tbl[6] = '{{5'd12, 3'd1}, 32'h5555_5555, 32'h0000_0000};
    tbl[7] = '{{5'd0, 3'd0},  32'hAAAA_AAAA, 32'h0000_0000};
    tbl[8] = '{CP0_COMPARE,  32'h0000_1000, TIMER_ON ? 32'h0000_1000 : 32'h0};
    tbl[9] = '{CP0_COUNT,    32'h0000_0100, TIMER_ON ? 32'h0000_0100 : 32'h0};
    for (int i = 0; i < 10; i++) begin
      wr(tbl[i].addr, tbl[i].wdata);
      rd(tbl[i].addr);
      chk($sformatf("tbl%0d", i), s_rdata, tbl[i].exp);
    end

    // syscall
    v = idle(); v.valid = 1; v.sys = 1; v.pc = 32'h40;
    cyc(v);
    chk("sys_exc_bus", s_exc, {1'b1, EXC_BASE_TB});
    rd(CP0_EPC);    chk("sys_epc", s_rdata, 32'h40);
    rd(CP0_CAUSE);  chk("sys_cause", s_rdata, 32'h20);
    rd(CP0_STATUS); chk("sys_status", s_rdata, 32'h2);

    // eret
    wr(CP0_EPC, 32'h44);
    v = idle(); v.valid = 1; v.eret = 1; v.pc = 32'h80;
    cyc(v);
    chk("eret_exc_bus", s_exc, {1'b1, 32'h44});
    chk("eret_cancel", s_cancel, 1'b1);
    rd(CP0_STATUS); chk("eret_status", s_rdata, 32'h0);

    // adel in delay slot
    v = idle(); v.valid = 1; v.adel = 1; v.bd = 1; v.pc = 32'h100; v.bva = 32'h3;
    cyc(v);
    rd(CP0_EPC);      chk("adel_epc", s_rdata, 32'hFC);
    rd(CP0_CAUSE);    chk("adel_cause", s_rdata, 32'h8000_0010);
    rd(CP0_BADVADDR); chk("adel_bva", s_rdata, 32'h3);

    // interrupt beats ov; nested ov keeps EPC
    wr(CP0_STATUS, 32'h0000_0401);
    cur_hw = 6'd1;
    cyc(idle());
    v = idle(); v.valid = 1; v.ov = 1; v.pc = 32'h500;
    cyc(v);
    chk("int_pend_before", s_pend, 1'b1);
    rd(CP0_CAUSE); chk("int_cause", s_rdata, 32'h400);
    rd(CP0_EPC);   chk("int_epc", s_rdata, 32'h500);
    v = idle(); v.valid = 1; v.ov = 1; v.pc = 32'h600;
    cyc(v);
    chk("nested_exc_bus", s_exc, {1'b1, EXC_BASE_TB});
    rd(CP0_CAUSE); chk("nested_cause", s_rdata, 32'h430);
    rd(CP0_EPC);   chk("nested_epc", s_rdata, 32'h500);

    // mtc0 suppressed by a same-cycle exception
    cur_hw = 6'd0;
    wr(CP0_STATUS, 32'h0);
    v = idle(); v.valid = 1; v.sys = 1; v.pc = 32'h200;
    v.mtc0 = 1; v.addr = CP0_EPC; v.wdata = 32'h999;
    cyc(v);
    rd(CP0_EPC); chk("suppress_epc", s_rdata, 32'h200);

    // reset asserted mid-exception
    wr(CP0_STATUS, 32'h0000_FF03);
    @(posedge clk); #1;
    v = idle(); v.valid = 1; v.sys = 1; v.eret = 1; v.pc = 32'h300;
    v.mfc0 = 1; v.addr = CP0_STATUS;
    drive(v);
    #1 resetn = 0;
    #1;
    m_reset();
    chk("inrst_exc_bus", bus.exc_bus, 33'h0);
    chk("inrst_cancel", bus.cancel, 1'b0);
    chk("inrst_int_pending", bus.int_pending, 1'b0);
    chk("inrst_rdata", bus.cp0_rdata, 32'h0);
    @(negedge clk);
    drive(idle());
    resetn = 1;
    rd(CP0_STATUS);   chk("post_rst_status", s_rdata, 32'h0);
    rd(CP0_CAUSE);    chk("post_rst_cause", s_rdata, 32'h0);
    rd(CP0_EPC);      chk("post_rst_epc", s_rdata, 32'h0);
    rd(CP0_BADVADDR); chk("post_rst_bva", s_rdata, 32'h0);
    rd(CP0_COMPARE);  chk("post_rst_compare", s_rdata, TIMER_ON ? 32'hFFFF_FFFF : 32'h0);

`ifdef CP0_TIMER_EN
    // timer interrupt: Count written 0 reaches Compare=5 five edges later
    do_reset();
    wr(CP0_COMPARE, 32'd5);
    wr(CP0_STATUS, 32'h0000_8001);
    wr(CP0_COUNT, 32'd0);
    n = 0; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      rd(CP0_CAUSE);
      n++;
      if (s_rdata[30]) found = 1;
    end
    chk("ti_seen_after", n, 6);
    cyc(idle());
    chk("timer_int_pending", s_pend, 1'b1);
    v = idle(); v.valid = 1; v.pc = 32'h700;
    cyc(v);
    chk("timer_exc_bus", s_exc, {1'b1, EXC_BASE_TB});
    rd(CP0_CAUSE); chk("timer_cause", s_rdata, 32'h4000_8000);
    wr(CP0_COMPARE, 32'd7);
    rd(CP0_CAUSE); r = s_rdata; chk("compare_clears_ti", r[30], 1'b0);
    // clear beats a same-cycle match
    wr(CP0_STATUS, 32'h0);
    wr(CP0_COMPARE, 32'd3);
    wr(CP0_COUNT, 32'd2);
    wr(CP0_COMPARE, 32'd3);
    rd(CP0_CAUSE); r = s_rdata; chk("clear_wins", r[30], 1'b0);
    // wrap through zero
    wr(CP0_COMPARE, 32'd0);
    wr(CP0_COUNT, 32'hFFFF_FFFE);
    cyc(idle());
    rd(CP0_COUNT); chk("count_max", s_rdata, 32'hFFFF_FFFF);
    rd(CP0_CAUSE); r = s_rdata; chk("wrap_ti", r[30], 1'b1);
    rd(CP0_COUNT); chk("count_wrapped", s_rdata, 32'h1);
`else
    wr(CP0_COUNT, 32'h55);
    rd(CP0_COUNT); chk("no_timer_count", s_rdata, 32'h0);
    rd(CP0_CAUSE); r = s_rdata; chk("no_timer_ti", r[30], 1'b0);
`endif

    // randomized traffic against the model
    do_reset();
    alist[0] = CP0_STATUS; alist[1] = CP0_CAUSE; alist[2] = CP0_EPC;
    alist[3] = CP0_BADVADDR; alist[4] = CP0_COUNT; alist[5] = CP0_COMPARE;
    alist[6] = {5'd12, 3'd2}; alist[7] = {5'd3, 3'd0};
    for (int i = 0; i < 500; i++) begin
      v = '0;
      r = $urandom;
      v.pc = {r[31:2], 2'b00};
      v.bd = ($urandom_range(0, 3) == 0);
      v.valid = ($urandom_range(0, 2) == 0);
      v.sys  = ($urandom_range(0, 9) == 0);
      v.brk  = ($urandom_range(0, 9) == 0);
      v.eret = ($urandom_range(0, 5) == 0);
      v.ov   = ($urandom_range(0, 9) == 0);
      v.adel = ($urandom_range(0, 9) == 0);
      v.ades = ($urandom_range(0, 9) == 0);
      v.bva = $urandom;
      v.mtc0 = ($urandom_range(0, 3) == 0);
      v.mfc0 = ($urandom_range(0, 1) == 0);
      v.addr = alist[$urandom_range(0, 7)];
      v.wdata = $urandom;
      if (v.addr == CP0_COMPARE || v.addr == CP0_COUNT)
        v.wdata = {28'd0, v.wdata[3:0]};
      if ($urandom_range(0, 15) == 0) cur_hw = 6'($urandom);
      v.hw = cur_hw;
      cyc(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
